// File: rtl/mantissa_square_seq.sv
// Sequential shift-add squarer for normalized 1.f mantissas, one multiplier bit per clock.
// Optional round-to-nearest-even on the result is enabled by defining SQUARE_RNE_EN.
module mantissa_square_seq #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-2:0] a,
    output logic            busy,
    output logic            valid,
    output logic [SIZE-2:0] mant_out,
    output logic [1:0]      exp_adj,
    output logic            inexact
);
    localparam int MW = SIZE - 1;
    localparam int CW = $clog2(MW) + 1;
    localparam int PW = 2 * MW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [MW-1:0]   a_q;
    logic [MW-1:0]   b_q;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   p_next;
    logic [MW:0]     p_hi;
    logic [CW-1:0]   cnt_q;
    logic            last_iter;

    logic [MW-1:0]   mant;
    logic            guard;
    logic            sticky;
    logic [1:0]      adj;
    logic [MW-1:0]   mant_fin;
    logic [1:0]      adj_fin;

    assign busy      = (state_q != IDLE);
    assign last_iter = (cnt_q == CW'(MW - 1));

    // Add the operand into the upper half when the current multiplier bit is set, then shift.
    assign p_hi   = p_q[PW-1:MW] + (b_q[0] ? {1'b0, a_q} : '0);
    assign p_next = {p_hi, p_q[MW-1:0]} >> 1;

    always_comb begin
        // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (last_iter) state_d = NORM;
            NORM:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Square of a 1.f value lies in [1,4): pick the window under the leading one.
    always_comb begin
        if (p_q[2*MW-1]) begin
            mant   = p_q[2*MW-1:MW];
            guard  = p_q[MW-1];
            sticky = |p_q[MW-2:0];
            adj    = 2'd1;
        end else begin
            mant   = p_q[2*MW-2:MW-1];
            guard  = p_q[MW-2];
            sticky = |p_q[MW-3:0];
            adj    = 2'd0;
        end
    end

`ifdef SQUARE_RNE_EN
    logic          round_up;
    logic [MW:0]   mant_inc;

    assign round_up = guard & (sticky | mant[0]);
    assign mant_inc = {1'b0, mant} + {{MW{1'b0}}, round_up};

    always_comb begin
        if (mant_inc[MW]) begin
            mant_fin = {1'b1, {(MW-1){1'b0}}};
            adj_fin  = adj + 2'd1;
        end else begin
            mant_fin = mant_inc[MW-1:0];
            adj_fin  = adj;
        end
    end
`else
    assign mant_fin = mant;
    assign adj_fin  = adj;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            valid    <= 1'b0;
            mant_out <= '0;
            exp_adj  <= '0;
            inexact  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid <= (state_q == NORM);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= a;
                        p_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                MUL: begin
                    p_q   <= p_next;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                NORM: begin
                    mant_out <= mant_fin;
                    exp_adj  <= adj_fin;
                    inexact  <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_square_seq.sv
// Self-checking bench for mantissa_square_seq (SIZE=8): cycle-level reference model plus directed vectors.
module tb_mantissa_square_seq;
    localparam int SIZE = 8;
    localparam int MW   = SIZE - 1;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [1:0]    adj;
        logic          inex;
    } res_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [MW-1:0] a;
    logic          busy;
    logic          valid;
    logic [MW-1:0] mant_out;
    logic [1:0]    exp_adj;
    logic          inexact;

    int checks = 0;
    int errors = 0;

    mantissa_square_seq #(.SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .busy     (busy),
        .valid    (valid),
        .mant_out (mant_out),
        .exp_adj  (exp_adj),
        .inexact  (inexact)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: exact integer square, normalize, then optionally round half-to-even.
    function automatic res_t sq_model(input logic [MW-1:0] op);
        int   prod;
        int   keep;
        int   rem;
        int   half;
        res_t r;
        prod = int'(op) * int'(op);
        if (prod >= (1 << (2*MW-1))) begin
            r.adj = 2'd1;
            keep  = prod >> MW;
            rem   = prod % (1 << MW);
            half  = 1 << (MW-1);
        end else begin
            r.adj = 2'd0;
            keep  = prod >> (MW-1);
            rem   = prod % (1 << (MW-1));
            half  = 1 << (MW-2);
        end
        r.inex = (rem != 0);
`ifdef SQUARE_RNE_EN
        if (rem > half || (rem == half && (keep % 2) == 1)) keep = keep + 1;
        if (keep == (1 << MW)) begin
            keep  = keep >> 1;
            r.adj = r.adj + 2'd1;
        end
`endif
        r.mant = keep[MW-1:0];
        return r;
    endfunction

    // Cycle model: an accepted request produces its result MW+1 edges later.
    int   remain;
    res_t pending;
    res_t m_out;
    logic m_valid;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain  <= 0;
            pending <= '0;
            m_out   <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= (remain == 1);
            if (remain == 1) m_out <= pending;
            if (remain > 0) begin
                remain <= remain - 1;
            end else if (start) begin
                remain  <= MW + 1;
                pending <= sq_model(a);
            end
        end
    end

    always @(negedge clk) begin
        check("busy",     {31'b0, busy},     {31'b0, (remain != 0)});
        check("valid",    {31'b0, valid},    {31'b0, m_valid});
        check("mant_out", {25'b0, mant_out}, {25'b0, m_out.mant});
        check("exp_adj",  {30'b0, exp_adj},  {30'b0, m_out.adj});
        check("inexact",  {31'b0, inexact},  {31'b0, m_out.inex});
    end

    task automatic run_op(input string name, input logic [MW-1:0] op,
                          input logic [MW-1:0] e_mant, input logic [1:0] e_adj, input logic e_inex);
        int n;
        @(negedge clk);
        a     = op;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, MW + 1);
        check({name, "_valid"},   {31'b0, valid},    32'd1);
        check({name, "_mant"},    {25'b0, mant_out}, {25'b0, e_mant});
        check({name, "_adj"},     {30'b0, exp_adj},  {30'b0, e_adj});
        check({name, "_inex"},    {31'b0, inexact},  {31'b0, e_inex});
    endtask

    initial begin
        res_t r;
        int   vcount;
        start = 1'b0;
        a     = '0;
        rst   = 1'b0;

        // Pin the reference model against hand-computed squares.
        r = sq_model(7'b1011011);
`ifdef SQUARE_RNE_EN
        check("model_91_mant", {25'b0, r.mant}, 32'b1000001);
`else
        check("model_91_mant", {25'b0, r.mant}, 32'b1000000);
`endif
        check("model_91_inex", {31'b0, r.inex}, 32'd1);
        r = sq_model(7'b1111111);
        check("model_127_mant", {25'b0, r.mant}, 32'b1111110);
        check("model_127_adj",  {30'b0, r.adj},  32'd1);

        repeat (3) @(negedge clk);
        check("rst_mant", {25'b0, mant_out}, 32'd0);
        check("rst_busy", {31'b0, busy},     32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("one",     7'b1000000, 7'b1000000, 2'd0, 1'b0);
        run_op("onehalf", 7'b1100000, 7'b1001000, 2'd1, 1'b0);
`ifdef SQUARE_RNE_EN
        run_op("a91",     7'b1011011, 7'b1000001, 2'd1, 1'b1);
`else
        run_op("a91",     7'b1011011, 7'b1000000, 2'd1, 1'b1);
`endif
        run_op("a127",    7'b1111111, 7'b1111110, 2'd1, 1'b1);

        // Start held high: E3 request ignored, second capture at E9.
        @(negedge clk);
        a      = 7'b1100000;
        start  = 1'b1;
        vcount = 0;
        @(posedge clk);
        @(negedge clk);
        for (int e = 1; e <= 17; e++) begin
            if (e == 3) a = 7'b1000000;
            @(posedge clk);
            @(negedge clk);
            if (valid) vcount++;
            if (e == 8) begin
                check("b2b_first_valid", {31'b0, valid},    32'd1);
                check("b2b_first_mant",  {25'b0, mant_out}, 32'b1001000);
                check("b2b_first_adj",   {30'b0, exp_adj},  32'd1);
            end
            if (e == 17) begin
                check("b2b_second_valid", {31'b0, valid},    32'd1);
                check("b2b_second_mant",  {25'b0, mant_out}, 32'b1000000);
                check("b2b_second_adj",   {30'b0, exp_adj},  32'd0);
            end
        end
        start = 1'b0;
        check("b2b_valid_count", vcount, 2);

        // Reset at E4 of an operation: outputs clear at once, no result strobe.
        @(negedge clk);
        a     = 7'b1111111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_mant",  {25'b0, mant_out}, 32'd0);
        check("abort_adj",   {30'b0, exp_adj},  32'd0);
        check("abort_inex",  {31'b0, inexact},  32'd0);
        check("abort_busy",  {31'b0, busy},     32'd0);
        check("abort_valid", {31'b0, valid},    32'd0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid) vcount++;
            if (i == 3) rst = 1'b1;
        end
        check("abort_no_valid", vcount, 0);
        run_op("post_rst", 7'b1000000, 7'b1000000, 2'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mantissa_square_seq.md
# mantissa_square_seq

Sequential shift-add squarer for normalized `1.f` floating-point mantissas, one multiplier bit per clock. It is the inverse-direction companion of the FPU's iterative square-root unit and sits beside it in the FPU datapath. It accepts an operand of the same width the square-root unit produces. It returns the normalized square, an exponent adjustment and an inexact flag.

## Interface
- `SIZE`, default 8: datapath size parameter. Operand and result width `MW = SIZE-1`; `MW >= 3`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request. Sampled only in IDLE.
- `a`  in  `MW`  operand `1.f`. MSB is the hidden one.
- `busy`  out  1  high whenever the state is not IDLE.
- `valid`  out  1  one-cycle result strobe.
- `mant_out`  out  `MW`  normalized result `1.f`, leading one included.
- `exp_adj`  out  2  exponent increment to add to the doubled exponent: 0, 1 or 2.
- `inexact`  out  1  set when any discarded product bit is nonzero.

## Operation
- Registers:
  - operand copy `A` (`MW` bits).
  - multiplier shift register `B` (`MW` bits).
  - product accumulator `P` (`2*MW+1` bits, including the carry bit).
  - iteration counter `cnt` (`$clog2(MW)+1` bits).
  - 2-bit state.
- IDLE:
  - If `start` is high: `A<=a`, `B<=a`, `P<=0`, `cnt<=0`, go to MUL.
  - Otherwise stay in IDLE.
- MUL, once per edge:
  - `P_hi = P[2MW:MW] + (B[0] ? A : 0)`.
  - `P <= {P_hi, P[MW-1:0]} >> 1`.
  - `B <= B >> 1`.
  - `cnt <= cnt+1`.
  - When `cnt == MW-1`, go to NORM.
  - After `MW` iterations, `P[2MW-1:0] == a*a` exactly.
- NORM, one edge:
  - Register the outputs, pulse `valid`, return to IDLE.
- Normalization:
  - If `P[2MW-1]=1`: `mant=P[2MW-1:MW]`, `guard=P[MW-1]`, `sticky=|P[MW-2:0]`, `exp_adj=1`.
  - Else: `mant=P[2MW-2:MW-1]`, `guard=P[MW-2]`, `sticky=|P[MW-3:0]`, `exp_adj=0`.
- `inexact = guard | sticky`. This is independent of the rounding mode.
- Illegal operand (`a[MW-1]=0`): no error is raised. The else-branch is applied deterministically, and `mant_out` may then have a zero MSB.
- `start` while `busy` is ignored. There is no queueing.
- Output ports hold their last value until the next NORM edge.

## Timing
- Reset (async, `rst=0`):
  - state IDLE.
  - `busy=0`, `valid=0`.
  - `mant_out=0`, `exp_adj=0`, `inexact=0`.
  - `P`, `A`, `B`, `cnt` all cleared.
- Reset is effective immediately, including mid-MUL or mid-NORM. The aborted operation produces no `valid`.
- Latency and throughput:
  - `start` is captured at edge E0.
  - MUL occupies edges E1..E(MW).
  - NORM is edge E(MW+1), which raises `valid`.
  - `valid` deasserts at E(MW+2).
  - `busy` is high from after E0 until E(MW+1).
  - A new `start` is accepted at E(MW+2) at the earliest, so throughput is one result per `MW+2` cycles.
- `start` held high continuously produces back-to-back operations with `MW+2` cycle spacing.
- `valid` is never high for more than one consecutive cycle.

## Configuration
- `SQUARE_RNE_EN` defined: round to nearest even.
  - Increment `mant` if `guard & (sticky | mant[0])`.
  - On carry-out, `mant_out = {1'b1,{(MW-1){1'b0}}}` and `exp_adj` is incremented (reaching 1 or 2).
  - Rounding is folded into the NORM edge, so latency is unchanged.
- `SQUARE_RNE_EN` undefined: truncation.
  - `mant_out = mant`, and `exp_adj` is 0 or 1 only.
  - No incrementer is present.

## Test plan
All scenarios use `SIZE=8` (`MW=7`).
- `a=7'b1000000` (1.0), `start` pulse:
  - `valid` 8 cycles after the capture edge.
  - `mant_out=7'b1000000`, `exp_adj=0`, `inexact=0`.
- `a=7'b1100000` (1.5):
  - `mant_out=7'b1001000` (1.125), `exp_adj=1`, `inexact=0`.
- `a=7'b1011011` (91, product 8281):
  - Truncation build: `mant_out=7'b1000000`, `exp_adj=1`, `inexact=1`.
  - `SQUARE_RNE_EN` build: `mant_out=7'b1000001`, `exp_adj=1`, `inexact=1`.
- `a=7'b1111111` (product 16129):
  - `mant_out=7'b1111110`, `exp_adj=1`, `inexact=1` in both builds (guard=0).
- Start during busy, then back-to-back:
  - Set `a=1.5`, hold `start` high continuously, and change `a` to `1.0` at E3.
  - The E3 request is ignored.
  - The second capture occurs at E9 with `a=1.0`.
  - `valid` pulses after E8 (1.5 result) and after E17 (1.0 result).
- Reset mid-operation:
  - Drop `rst` at E4 of an operation.
  - All outputs read 0 immediately.
  - No `valid` occurs.
  - After release, a fresh `start` with `a=1.0` completes normally with the 8-cycle latency.
